// File: rtl/mult_simd_pipe_pkg.sv
// Shared defaults and index helpers for the SIMD activation x weight multiplier.
package mult_simd_pipe_pkg;

  localparam int unsigned PICTURE_NUM_DEF    = 8;
  localparam int unsigned WIDTH_DATA_DEF     = 8;
  localparam int unsigned WIDTH_DATA_OUT_DEF = 10;

  // Distance between the lo and hi operand inside a packed multiplier operand.
  function automatic int unsigned pack_shift(input int unsigned w);
    return 2 * w;
  endfunction

  // Width of one packed multiplier product.
  function automatic int unsigned prod_w(input int unsigned w);
    return 4 * w;
  endfunction

  // Width of one output lane.
  function automatic int unsigned out_lane_w(input int unsigned wo);
    return 2 * wo;
  endfunction

  // LSB index of lane i in a bus of lanes that are w bits wide.
  function automatic int unsigned lane_lsb(input int unsigned i, input int unsigned w);
    return i * w;
  endfunction

endpackage

// File: rtl/mult_pack_pair.sv
// S2/S3 datapath for one lane pair (LANES=2) or a lone odd lane (LANES=1).
module mult_pack_pair
  import mult_simd_pipe_pkg::*;
#(
  parameter int unsigned WIDTH_DATA = WIDTH_DATA_DEF,
  parameter int unsigned OUT_LANE_W = 2 * WIDTH_DATA_OUT_DEF,
  parameter int unsigned SIGNED     = 1,
  parameter int unsigned PACK       = 1,
  parameter int unsigned LANES      = 2
) (
  input  logic                             clk,
  input  logic                             rst_n,
  input  logic                             en2,
  input  logic                             en3,
  input  logic [LANES*WIDTH_DATA-1:0]      a,
  input  logic [WIDTH_DATA-1:0]            weight,
  output logic [LANES*OUT_LANE_W-1:0]      res
);

  localparam int unsigned W  = WIDTH_DATA;
  localparam int unsigned S  = pack_shift(W);
  localparam int unsigned PW = prod_w(W);
  localparam bit          SX = (SIGNED != 0);
  // Bits of an output lane above the S-bit lane product; filled with the sign when SIGNED.
  localparam logic [OUT_LANE_W-1:0] EXT_MASK = ~OUT_LANE_W'({S{1'b1}});

  generate
    if (LANES == 2) begin : g_pair
      logic [W-1:0]  a_lo;
      logic [W-1:0]  a_hi;
      logic [PW-1:0] p2_d;
      logic [PW-1:0] p2_q;
      logic [S-1:0]  hi_raw;

      assign a_lo = a[W-1:0];
      assign a_hi = a[2*W-1:W];

      if (PACK != 0) begin : g_packed
        logic [PW-1:0] op_a;
        logic [PW-1:0] op_w;
        // One multiplier for both lanes: (hi*2^S + lo) * weight, operands extended to product width
        // so the combined operand (which needs 3*W+1 bits at hi=lo=-2^(W-1)) never wraps.
        always_comb begin
          op_a = {{W{SX & a_hi[W-1]}}, a_hi, {S{1'b0}}} + {{(3*W){SX & a_lo[W-1]}}, a_lo};
          op_w = {{(3*W){SX & weight[W-1]}}, weight};
          p2_d = op_a * op_w;
        end
      end else begin : g_split
        logic [S-1:0] lo_s;
        logic [S-1:0] hi_s;
        logic [S-1:0] w_s;
        // Two independent lane multipliers, laid out like the packed product.
        always_comb begin
          lo_s = {{W{SX & a_lo[W-1]}}, a_lo};
          hi_s = {{W{SX & a_hi[W-1]}}, a_hi};
          w_s  = {{W{SX & weight[W-1]}}, weight};
          p2_d = {hi_s * w_s, lo_s * w_s};
        end
      end

      // S2: raw product register (absorbed into the multiplier's pipeline register).
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          p2_q <= '0;
        end else if (en2) begin
          p2_q <= p2_d;
        end
      end

      // Borrow correction: a negative lo product has taken one from the hi field.
      always_comb begin
        hi_raw = p2_q[PW-1:S] + S'((PACK != 0) && SX && p2_q[S-1]);
      end

      // S3: correction result and lane extension, registered as data_out.
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          res <= '0;
        end else if (en3) begin
          res[OUT_LANE_W-1:0]            <= OUT_LANE_W'(p2_q[S-1:0]) |
                                            (EXT_MASK & {OUT_LANE_W{SX & p2_q[S-1]}});
          res[2*OUT_LANE_W-1:OUT_LANE_W] <= OUT_LANE_W'(hi_raw) |
                                            (EXT_MASK & {OUT_LANE_W{SX & hi_raw[S-1]}});
        end
      end
    end else begin : g_single
      logic [S-1:0] a_s;
      logic [S-1:0] w_s;
      logic [S-1:0] p2_d;
      logic [S-1:0] p2_q;

      // Unpacked multiplier for the odd last lane.
      always_comb begin
        a_s  = {{W{SX & a[W-1]}}, a[W-1:0]};
        w_s  = {{W{SX & weight[W-1]}}, weight};
        p2_d = a_s * w_s;
      end

      // S2: raw product register.
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          p2_q <= '0;
        end else if (en2) begin
          p2_q <= p2_d;
        end
      end

      // S3: lane extension, registered as data_out.
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          res <= '0;
        end else if (en3) begin
          res <= OUT_LANE_W'(p2_q) | (EXT_MASK & {OUT_LANE_W{SX & p2_q[S-1]}});
        end
      end
    end
  endgenerate

endmodule

// File: rtl/mult_simd_pipe.sv
// SIMD activation x shared weight multiplier with a 3-stage valid/ready pipeline.
module mult_simd_pipe
  import mult_simd_pipe_pkg::*;
#(
  parameter int unsigned PICTURE_NUM    = PICTURE_NUM_DEF,
  parameter int unsigned WIDTH_DATA     = WIDTH_DATA_DEF,
  parameter int unsigned WIDTH_DATA_OUT = WIDTH_DATA_OUT_DEF,
  parameter int unsigned SIGNED         = 1,
  parameter int unsigned PACK           = 1
) (
  input  logic                                    clk,
  input  logic                                    rst_n,
  input  logic                                    flush,
  input  logic                                    in_valid,
  output logic                                    in_ready,
  input  logic [PICTURE_NUM*WIDTH_DATA-1:0]       data_in,
  input  logic [WIDTH_DATA-1:0]                   weight_in,
  output logic                                    out_valid,
  input  logic                                    out_ready,
  output logic [PICTURE_NUM*2*WIDTH_DATA_OUT-1:0] data_out
);

  localparam int unsigned W          = WIDTH_DATA;
  localparam int unsigned OUT_LANE_W = out_lane_w(WIDTH_DATA_OUT);
  localparam int unsigned NPAIR      = PICTURE_NUM / 2;
  localparam bit          ODD        = (PICTURE_NUM % 2) != 0;

  logic                        v1, v2, v3;
  logic                        ld1_c, ld2_c, ld3_c;
  logic                        en2_c, en3_c;
  logic [PICTURE_NUM*W-1:0]    d1;
  logic [W-1:0]                w1;

  // Stage advance chain: a stage loads when empty or when the stage after it loads.
  always_comb begin
    ld3_c = !v3 || out_ready;
    ld2_c = !v2 || ld3_c;
    ld1_c = !v1 || ld2_c;
    en2_c = ld2_c && v1;
    en3_c = ld3_c && v2;
  end

  assign in_ready  = ld1_c;
  assign out_valid = v3;

  // Stage valids; flush empties the pipe and wins over a simultaneous accept.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      v1 <= 1'b0;
      v2 <= 1'b0;
      v3 <= 1'b0;
    end else if (flush) begin
      v1 <= 1'b0;
      v2 <= 1'b0;
      v3 <= 1'b0;
    end else begin
      if (ld1_c) v1 <= in_valid;
      if (ld2_c) v2 <= v1;
      if (ld3_c) v3 <= v2;
    end
  end

  // S1: input register for activations and weight.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      d1 <= '0;
      w1 <= '0;
    end else if (ld1_c && in_valid) begin
      d1 <= data_in;
      w1 <= weight_in;
    end
  end

  generate
    for (genvar j = 0; j < NPAIR; j++) begin : g_pair
      mult_pack_pair #(
        .WIDTH_DATA (W),
        .OUT_LANE_W (OUT_LANE_W),
        .SIGNED     (SIGNED),
        .PACK       (PACK),
        .LANES      (2)
      ) u_pair (
        .clk    (clk),
        .rst_n  (rst_n),
        .en2    (en2_c),
        .en3    (en3_c),
        .a      (d1[lane_lsb(2*j, W) +: 2*W]),
        .weight (w1),
        .res    (data_out[lane_lsb(2*j, OUT_LANE_W) +: 2*OUT_LANE_W])
      );
    end

    if (ODD) begin : g_odd
      mult_pack_pair #(
        .WIDTH_DATA (W),
        .OUT_LANE_W (OUT_LANE_W),
        .SIGNED     (SIGNED),
        .PACK       (PACK),
        .LANES      (1)
      ) u_last (
        .clk    (clk),
        .rst_n  (rst_n),
        .en2    (en2_c),
        .en3    (en3_c),
        .a      (d1[lane_lsb(PICTURE_NUM-1, W) +: W]),
        .weight (w1),
        .res    (data_out[lane_lsb(PICTURE_NUM-1, OUT_LANE_W) +: OUT_LANE_W])
      );
    end
  endgenerate

endmodule

// File: tb/tb_mult_simd_pipe.sv
// Bench for mult_simd_pipe: directed table, backpressure/flush/reset sequences,
// random stream with scoreboard, and a small configuration sweep.
module tb_mult_simd_pipe;

  localparam int unsigned PN = 8;
  localparam int unsigned W  = 8;
  localparam int unsigned OW = 20;

  logic               clk = 1'b0;
  logic               rst_n;
  logic               flush;
  logic               in_valid;
  logic               in_ready;
  logic [PN*W-1:0]    data_in;
  logic [W-1:0]       weight_in;
  logic               out_valid;
  logic               out_ready;
  logic [PN*OW-1:0]   data_out;

  logic               cfg_valid;
  logic               cfg_flush;
  logic               cfg_ordy;
  logic [39:0]        cfg_d5;
  logic [63:0]        cfg_d8;
  logic [7:0]         cfg_w;
  logic               p5a_ir, p5a_ov, p5b_ir, p5b_ov, uns_ir, uns_ov;
  logic [99:0]        p5a_do, p5b_do;
  logic [159:0]       uns_do;

  int n_cmp = 0;
  int n_err = 0;

  typedef struct {
    logic [63:0] data;
    logic [7:0]  w;
    logic [19:0] exp0;
    logic [19:0] exp1;
  } vec_t;

  vec_t tbl [7];
  logic [159:0] q [$];

  always #5 clk = ~clk;

  mult_simd_pipe #(.PICTURE_NUM(8), .WIDTH_DATA(8), .WIDTH_DATA_OUT(10), .SIGNED(1), .PACK(1)) u_dut (
    .clk(clk), .rst_n(rst_n), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
    .data_in(data_in), .weight_in(weight_in), .out_valid(out_valid), .out_ready(out_ready),
    .data_out(data_out));

  mult_simd_pipe #(.PICTURE_NUM(5), .WIDTH_DATA(8), .WIDTH_DATA_OUT(10), .SIGNED(1), .PACK(1)) u_p5_pack (
    .clk(clk), .rst_n(rst_n), .flush(cfg_flush), .in_valid(cfg_valid), .in_ready(p5a_ir),
    .data_in(cfg_d5), .weight_in(cfg_w), .out_valid(p5a_ov), .out_ready(cfg_ordy),
    .data_out(p5a_do));

  mult_simd_pipe #(.PICTURE_NUM(5), .WIDTH_DATA(8), .WIDTH_DATA_OUT(10), .SIGNED(1), .PACK(0)) u_p5_nopack (
    .clk(clk), .rst_n(rst_n), .flush(cfg_flush), .in_valid(cfg_valid), .in_ready(p5b_ir),
    .data_in(cfg_d5), .weight_in(cfg_w), .out_valid(p5b_ov), .out_ready(cfg_ordy),
    .data_out(p5b_do));

  mult_simd_pipe #(.PICTURE_NUM(8), .WIDTH_DATA(8), .WIDTH_DATA_OUT(10), .SIGNED(0), .PACK(1)) u_uns (
    .clk(clk), .rst_n(rst_n), .flush(cfg_flush), .in_valid(cfg_valid), .in_ready(uns_ir),
    .data_in(cfg_d8), .weight_in(cfg_w), .out_valid(uns_ov), .out_ready(cfg_ordy),
    .data_out(uns_do));

  // Exact lane product, truncated to the 20-bit output lane.
  function automatic logic [19:0] ref_lane(input logic [7:0] a, input logic [7:0] w, input bit sgn);
    int av;
    int wv;
    av = sgn ? int'($signed(a)) : int'(a);
    wv = sgn ? int'($signed(w)) : int'(w);
    return 20'(av * wv);
  endfunction

  // Expected data_out for the first n lanes of d.
  function automatic logic [159:0] ref_vec(input logic [63:0] d, input logic [7:0] w,
                                           input bit sgn, input int n);
    logic [159:0] r;
    r = '0;
    for (int i = 0; i < n; i++) r[20*i +: 20] = ref_lane(d[8*i +: 8], w, sgn);
    return r;
  endfunction

  task automatic check(input string name, input logic [159:0] got, input logic [159:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic run_cfg(input logic [63:0] d8, input logic [7:0] w, output logic [19:0] uns_l0);
    logic [159:0] e5;
    logic [159:0] eu;
    check("cfg_in_ready", 160'({p5a_ir, p5b_ir, uns_ir}), 160'(3'b111));
    cfg_d8 = d8;
    cfg_d5 = d8[39:0];
    cfg_w  = w;
    cfg_valid = 1'b1;
    tick();
    cfg_valid = 1'b0;
    tick();
    tick();
    e5 = ref_vec(d8, w, 1'b1, 5);
    eu = ref_vec(d8, w, 1'b0, 8);
    check("cfg_out_valid", 160'({p5a_ov, p5b_ov, uns_ov}), 160'(3'b111));
    check("p5_pack_data", 160'(p5a_do), 160'(e5[99:0]));
    check("p5_nopack_data", 160'(p5b_do), 160'(e5[99:0]));
    check("unsigned_data", uns_do, eu);
    uns_l0 = uns_do[19:0];
    tick();
  endtask

  initial begin
    #900000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

  initial begin
    int lat;
    int sent;
    int cyc;
    int acc;
    int emitted;
    bit hold_prev;
    bit fire;
    logic [159:0] held;
    logic [159:0] ev;
    logic [19:0]  l0;

    tbl[0] = '{64'h0000_0000_0000_03FE, 8'd5,  20'hFFFF6, 20'h0000F};
    tbl[1] = '{64'h8080_8080_8080_8080, 8'h80, 20'h04000, 20'h04000};
    tbl[2] = '{64'h807F_807F_807F_807F, 8'hFF, 20'hFFF81, 20'h00080};
    tbl[3] = '{64'h7F7F_7F7F_7F7F_7F7F, 8'h7F, 20'h03F01, 20'h03F01};
    tbl[4] = '{64'h7F80_7F80_7F80_7F80, 8'h7F, 20'hFC080, 20'h03F01};
    tbl[5] = '{64'hFF00_FF00_FF00_FF00, 8'h80, 20'h00000, 20'h00080};
    tbl[6] = '{64'hFF01_FF01_FF01_FF01, 8'hFF, 20'hFFFFF, 20'h00001};

    rst_n = 1'b0; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    data_in = '0; weight_in = '0;
    cfg_valid = 1'b0; cfg_flush = 1'b0; cfg_ordy = 1'b1;
    cfg_d5 = '0; cfg_d8 = '0; cfg_w = '0;

    // Reset state
    #12;
    check("rst_out_valid", 160'(out_valid), 160'(0));
    check("rst_data_out", data_out, 160'(0));
    tick();
    rst_n = 1'b1;
    tick();
    check("idle_in_ready", 160'(in_ready), 160'(1));

    // Directed vectors: latency, lanes 0/1 against hand values, full bus against the model
    for (int k = 0; k < 7; k++) begin
      data_in = tbl[k].data;
      weight_in = tbl[k].w;
      in_valid = 1'b1;
      lat = 0;
      do begin
        tick();
        in_valid = 1'b0;
        lat++;
      end while (!out_valid && lat < 10);
      check($sformatf("vec%0d_latency", k), 160'(lat), 160'(3));
      check($sformatf("vec%0d_lane0", k), 160'(data_out[19:0]), 160'(tbl[k].exp0));
      check($sformatf("vec%0d_lane1", k), 160'(data_out[39:20]), 160'(tbl[k].exp1));
      check($sformatf("vec%0d_bus", k), data_out, ref_vec(tbl[k].data, tbl[k].w, 1'b1, 8));
      tick();
    end

    // Random stream with random backpressure
    q.delete();
    sent = 0; cyc = 0; hold_prev = 1'b0; held = '0;
    while ((sent < 1000 || q.size() != 0) && cyc < 20000) begin
      in_valid  = (sent < 1000) && ($urandom_range(0, 3) != 0);
      data_in   = {$urandom, $urandom};
      weight_in = ($urandom_range(0, 7) == 0) ? 8'h80 : 8'($urandom);
      out_ready = 1'($urandom_range(0, 1));
      @(negedge clk);
      if (hold_prev) begin
        check("stall_valid_hold", 160'(out_valid), 160'(1));
        check("stall_data_hold", data_out, held);
      end
      if (in_valid && in_ready) begin
        q.push_back(ref_vec(data_in, weight_in, 1'b1, 8));
        sent++;
      end
      if (out_valid && out_ready) begin
        check("stream_expected_beat", 160'(q.size() != 0), 160'(1));
        if (q.size() != 0) check("stream_data", data_out, q.pop_front());
      end
      hold_prev = out_valid && !out_ready;
      held = data_out;
      tick();
      cyc++;
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    check("stream_sent", 160'(sent), 160'(1000));
    check("stream_leftover", 160'(q.size()), 160'(0));
    tick();
    tick();

    // Backpressure: out_ready low for 6 cycles with in_valid high
    q.delete();
    out_ready = 1'b0;
    in_valid = 1'b1;
    acc = 0;
    data_in = {$urandom, $urandom};
    weight_in = 8'($urandom);
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      fire = in_valid && in_ready;
      if (fire) begin
        q.push_back(ref_vec(data_in, weight_in, 1'b1, 8));
        acc++;
      end
      tick();
      if (fire) begin
        data_in = {$urandom, $urandom};
        weight_in = 8'($urandom);
      end
    end
    @(negedge clk);
    check("bp_accepted", 160'(acc), 160'(3));
    check("bp_in_ready_low", 160'(in_ready), 160'(0));
    check("bp_out_valid", 160'(out_valid), 160'(1));
    tick();
    in_valid = 1'b0;
    out_ready = 1'b1;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      check("drain_valid", 160'(out_valid), 160'(1));
      if (q.size() != 0) check("drain_data", data_out, q.pop_front());
      tick();
    end
    @(negedge clk);
    check("drain_empty", 160'(out_valid), 160'(0));
    tick();

    // Flush with two beats in flight and a third being offered
    in_valid = 1'b1;
    data_in = 64'h0102_0304_0506_0708;
    weight_in = 8'd3;
    tick();
    data_in = 64'h1111_2222_3333_4444;
    tick();
    flush = 1'b1;
    data_in = 64'h5555_6666_7777_7F7F;
    tick();
    flush = 1'b0;
    in_valid = 1'b0;
    check("flush_out_valid", 160'(out_valid), 160'(0));
    check("flush_in_ready", 160'(in_ready), 160'(1));
    emitted = 0;
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      if (out_valid) emitted++;
      tick();
    end
    check("flush_emitted", 160'(emitted), 160'(0));

    // Asynchronous reset while beats are in flight
    in_valid = 1'b1;
    data_in = 64'h0101_0101_0101_0101;
    weight_in = 8'd3;
    tick();
    tick();
    tick();
    check("pre_rst_valid", 160'(out_valid), 160'(1));
    check("pre_rst_data", data_out, ref_vec(64'h0101_0101_0101_0101, 8'd3, 1'b1, 8));
    in_valid = 1'b0;
    #2;
    rst_n = 1'b0;
    #1;
    check("rst_async_valid", 160'(out_valid), 160'(0));
    check("rst_async_data", data_out, 160'(0));
    #3;
    rst_n = 1'b1;
    emitted = 0;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      if (out_valid) emitted++;
      tick();
    end
    check("rst_emitted", 160'(emitted), 160'(0));

    // Configuration sweep: odd lane count packed/unpacked, unsigned mode
    run_cfg(64'hFFFF_FFFF_FFFF_FFFF, 8'hFF, l0);
    check("unsigned_255x255", 160'(l0), 160'(20'h0FE01));
    run_cfg(64'h8080_8080_8080_8080, 8'h80, l0);
    check("unsigned_128x128", 160'(l0), 160'(20'h04000));
    run_cfg(64'h7F80_7F80_7F80_7F80, 8'hFF, l0);
    for (int k = 0; k < 30; k++) begin
      ev = '0;
      run_cfg({$urandom, $urandom}, 8'($urandom), l0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
